// File: rtl/hazard_stall_ctrl.sv
// Purpose : decode-stage hazard/stall controller (load-use, branch-on-load, MDU busy) plus IF/ID redirect flush.
// Latency : stall/flush outputs are combinational in the current cycle; only the MDU busy FSM is registered.
// Backpres: stall freezes PC and IF/ID and bubbles ID/EX; a redirect seen while stalled is dropped.
//
// Optional feature macro: HAZARD_STAT_EN adds the stall_cycles / flush_count statistic ports.
//
// Ports:
//   clk, rstn              pipeline clock, asynchronous active-low reset
//   IFID_rs/rt/uses_rt     source registers of the instruction in ID
//   IFID_is_br/is_mdu      ID instruction class (branch/jr resolved in ID, MDU access)
//   IDEXE_RFWr/rd/DMRd     EX-stage writeback and load type
//   EXEMEM_rd/DMRd         MEM-stage destination and load type
//   IDEXE_mdu_start        mult/div in EX launches the MDU this cycle
//   npc_redirect           ID resolved a taken branch/jump this cycle
//   PC_Wr, IFID_Wr         write enables, low while stalled
//   IFID_flush             clear IF/ID on the next edge (taken redirect, not stalled)
//   IDEXE_flush            bubble into ID/EX on the next edge
//   mdu_busy               MDU window active
//   stall                  OR of all stall causes
//   stall_cycles, flush_count  (HAZARD_STAT_EN only) free-running wrap-around statistics

`ifndef DMRd_NOP
`define DMRd_NOP 4'b0000
`endif

module hazard_stall_ctrl #(
   parameter int MDU_LAT = 4,   // MDU busy cycles after a start, 1..15
   parameter int CNT_W   = 4    // counter width, 2**CNT_W must exceed MDU_LAT
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  IFID_rs,
   input  logic [4:0]  IFID_rt,
   input  logic        IFID_uses_rt,
   input  logic        IFID_is_br,
   input  logic        IFID_is_mdu,
   input  logic        IDEXE_RFWr,
   input  logic [4:0]  IDEXE_rd,
   input  logic [3:0]  IDEXE_DMRd,
   input  logic [4:0]  EXEMEM_rd,
   input  logic [3:0]  EXEMEM_DMRd,
   input  logic        IDEXE_mdu_start,
   input  logic        npc_redirect,
   output logic        PC_Wr,
   output logic        IFID_Wr,
   output logic        IFID_flush,
   output logic        IDEXE_flush,
   output logic        mdu_busy,
   output logic        stall
`ifdef HAZARD_STAT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_t;

   // Loading LAT-1 and leaving BUSY on the edge where the counter reads 0
   // gives exactly MDU_LAT busy cycles.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

   mdu_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic hit_ex;
   logic hit_mem;
   logic ld_use;
   logic br_ld_mem;
   logic mdu_hz;
   logic stall_raw;

   // ------------------------------------------------------------------
   // MDU busy-window FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (IDEXE_mdu_start) begin
               state_d = BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         BUSY: begin
            // A start seen here is impossible in a well-formed pipeline
            // (mdu_hz holds the mult/div in ID); it is ignored, no reload.
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign mdu_busy = (state_q == BUSY);

   // ------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------
   always_comb begin
      // Destination $0 is never a real producer, so it never matches.
      hit_ex  = (IDEXE_rd != 5'd0) &&
                ((IDEXE_rd == IFID_rs) || (IFID_uses_rt && (IDEXE_rd == IFID_rt)));
      hit_mem = (EXEMEM_rd != 5'd0) &&
                ((EXEMEM_rd == IFID_rs) || (IFID_uses_rt && (EXEMEM_rd == IFID_rt)));

      // Load in EX feeding ID: one bubble, forwarding covers the rest.
      ld_use    = (IDEXE_DMRd != `DMRd_NOP) && IDEXE_RFWr && hit_ex;
      // Branches resolve in ID and cannot take MEM-stage load data, so a
      // load-dependent branch waits one more cycle while the load is in MEM.
      br_ld_mem = IFID_is_br && (EXEMEM_DMRd != `DMRd_NOP) && hit_mem;
      mdu_hz    = IFID_is_mdu && mdu_busy;
   end

   // Gated by rstn so the pipeline free-runs while held in reset.
   assign stall_raw   = ld_use | br_ld_mem | mdu_hz;
   assign stall       = rstn & stall_raw;
   assign PC_Wr       = ~stall;
   assign IFID_Wr     = ~stall;
   assign IDEXE_flush = stall;
   // A stalled branch has not really resolved yet; drop its redirect.
   assign IFID_flush  = rstn & npc_redirect & ~stall_raw;

`ifdef HAZARD_STAT_EN
   // ------------------------------------------------------------------
   // Statistics, wrap modulo 2**32
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall)      stall_cycles <= stall_cycles + 32'd1;
         if (IFID_flush) flush_count  <= flush_count + 32'd1;
      end
   end
`endif

endmodule
